// File: rtl/ternary_line_packer_pkg.sv
// ternary_pkg -- shared definitions for the ternary line packer.
//
// Holds the 2-bit trit encodings, the default line length and the FSM state
// type, plus a helper that maps any incoming code onto a storable trit.
//
// Optional feature macro used by the packer: TERNARY_PACKER_ILLEGAL_CNT_EN.

package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO    = 2'b00;
  localparam logic [1:0] TRIT_POS     = 2'b01;
  localparam logic [1:0] TRIT_NEG     = 2'b10;
  localparam logic [1:0] TRIT_ILLEGAL = 2'b11;

  localparam int TRITS_PER_LINE_DEFAULT = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // The illegal code has no meaning in dense storage, so it is kept as zero.
  function automatic logic [1:0] cleanTrit(input logic [1:0] code);
    logic [1:0] result;
    case (code)
      TRIT_POS: result = TRIT_POS;
      TRIT_NEG: result = TRIT_NEG;
      default:  result = TRIT_ZERO;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ternary_line_packer.sv
// ternary_line_packer -- packs a stream of 2-bit trits into dense SRAM lines.
//
// Trits arriving on the s_* handshake are assembled into a line of
// TRITS_PER_LINE slots. A line is emitted as a one-cycle write (wr_en,
// wr_addr, wr_trits) when it fills or when the stream ends with s_last.
// Consecutive lines go to consecutive addresses starting at base_addr.
//
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   start, base_addr : begin a stream at the given line address (IDLE/DONE only)
//   s_valid, s_trit,
//   s_last, s_ready  : trit stream input handshake
//   wr_en, wr_addr,
//   wr_trits         : dense SRAM write port
//   busy, done       : FSM status (FILL / DONE)
//   lines_written    : lines written since the last start, saturating
//   err_cnt          : count of illegal trit codes accepted
//
// Build option: define TERNARY_PACKER_ILLEGAL_CNT_EN to enable err_cnt;
// otherwise err_cnt is tied to zero.

module ternary_line_packer
  import ternary_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TRITS_PER_LINE = TRITS_PER_LINE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic                        s_valid,
  input  logic [1:0]                  s_trit,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [2*TRITS_PER_LINE-1:0] wr_trits,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH:0]         lines_written,
  output logic [15:0]                 err_cnt
);

  localparam int IDX_W = (TRITS_PER_LINE > 1) ? $clog2(TRITS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(TRITS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH:0] LINES_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q;
  logic [2*TRITS_PER_LINE-1:0] asm_q, asm_d;
  logic [2*TRITS_PER_LINE-1:0] wr_trits_q;
  logic [ADDR_WIDTH-1:0]       base_q;
  logic [ADDR_WIDTH:0]         lines_q;
  logic                        wr_en_q;

  logic startTake;
  logic accept;
  logic flush;

  assign startTake = start && (state_q != FILL);
  assign accept    = s_valid && (state_q == FILL);
  assign flush     = accept && ((idx_q == LAST_IDX) || s_last);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (accept && s_last) state_d = DONE;
      DONE:    if (start) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs depend on the state alone, so s_ready never waits on s_valid
  always_comb begin
    s_ready = (state_q == FILL);
    busy    = (state_q == FILL);
    done    = (state_q == DONE);
  end

  // Assembly register with the incoming trit dropped into the current slot;
  // this is both the next assembly value and the line emitted on a flush
  always_comb begin
    asm_d = asm_q;
    asm_d[2*int'(idx_q) +: 2] = cleanTrit(s_trit);
  end

  // Line assembly, write strobe and line counting. Because the assembly
  // register is zeroed on every flush, slots beyond a short final line are
  // already zero when it is copied out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      asm_q      <= '0;
      wr_trits_q <= '0;
      base_q     <= '0;
      lines_q    <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      wr_en_q <= flush;
      if (startTake) begin
        base_q  <= base_addr;
        idx_q   <= '0;
        asm_q   <= '0;
        lines_q <= '0;
      end else begin
        if (wr_en_q && (lines_q != LINES_MAX)) begin
          lines_q <= lines_q + 1'b1;
        end
        if (flush) begin
          wr_trits_q <= asm_d;
          asm_q      <= '0;
          idx_q      <= '0;
        end else if (accept) begin
          asm_q <= asm_d;
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // lines_written only advances after the strobe cycle, so during wr_en it
  // still indexes the line being written; the sum wraps at the address width
  assign wr_addr       = base_q + lines_q[ADDR_WIDTH-1:0];
  assign wr_en         = wr_en_q;
  assign wr_trits      = wr_trits_q;
  assign lines_written = lines_q;

`ifdef TERNARY_PACKER_ILLEGAL_CNT_EN
  logic [15:0] err_q;

  // Saturating count of illegal codes accepted since the last start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (startTake) begin
      err_q <= '0;
    end else if (accept && (s_trit == TRIT_ILLEGAL) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule
